// File: rtl/i2c_target.sv
// 7-bit-address I2C target with oversampled SCL/SDA and open-drain SDA drive.
// Write bytes arrive with a one-cycle valid pulse; read bytes come from i_TX_Data.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_SCL,
  inout  wire        ino_SDA,
  input  logic [7:0] i_TX_Data,
  output logic [7:0] o_RX_Data,
  output logic       o_RX_Valid,
  output logic       o_TX_Done,
  output logic       o_Addr_Match,
  output logic       o_Busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] RX_DATA   = 3'd3;
  localparam logic [2:0] RX_ACK    = 3'd4;
  localparam logic [2:0] TX_DATA   = 3'd5;
  localparam logic [2:0] TX_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  logic       scl_meta, scl_sync, scl_prev;
  logic       sda_meta, sda_sync, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic       last_bit;
  logic [6:0] shift;
  logic [7:0] rx_byte;
  logic [6:0] tx_shift;
  logic       rw;
  logic       ack_phase;
  logic       sda_low;

  // Open-drain output: only ever pull low or let the bus float.
  assign ino_SDA = sda_low ? 1'b0 : 1'bz;

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & ~sda_prev & sda_sync;
  assign last_bit  = (bit_cnt == 3'd7);
  assign rx_byte   = {shift, sda_sync};

  // Two-flop synchronisers plus a previous-sample stage for edge detection; idle bus reads high.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= i_SCL;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= ino_SDA;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  // Protocol FSM: START/STOP override everything, otherwise sample on SCL rise and drive on SCL fall.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 7'd0;
      tx_shift     <= 7'd0;
      rw           <= 1'b0;
      ack_phase    <= 1'b0;
      sda_low      <= 1'b0;
      o_RX_Data    <= 8'd0;
      o_RX_Valid   <= 1'b0;
      o_TX_Done    <= 1'b0;
      o_Addr_Match <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      o_RX_Valid   <= 1'b0;
      o_TX_Done    <= 1'b0;
      o_Addr_Match <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 3'd0;
        sda_low <= 1'b0;
        o_Busy  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        sda_low <= 1'b0;
        o_Busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_low <= 1'b0;
          end
          ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                bit_cnt <= 3'd0;
                if (rx_byte[7:1] == TARGET_ADDR) begin
                  o_Addr_Match <= 1'b1;
                  o_Busy       <= 1'b1;
                  rw           <= rx_byte[0];
                  ack_phase    <= 1'b0;
                  state        <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_low   <= 1'b1;
                ack_phase <= 1'b1;
              end else if (rw) begin
                tx_shift <= i_TX_Data[6:0];
                sda_low  <= ~i_TX_Data[7];
                bit_cnt  <= 3'd0;
                state    <= TX_DATA;
              end else begin
                sda_low <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                bit_cnt    <= 3'd0;
                o_RX_Data  <= rx_byte;
                o_RX_Valid <= 1'b1;
                ack_phase  <= 1'b0;
                state      <= RX_ACK;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_low   <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= RX_DATA;
              end
            end
          end
          TX_DATA: begin
            if (scl_fall) begin
              if (last_bit) begin
                sda_low   <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                state     <= TX_ACK;
              end else begin
                sda_low  <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_sync) begin
                o_TX_Done <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                state   <= WAIT_STOP;
              end
            end else if (scl_fall && ack_phase) begin
              tx_shift  <= i_TX_Data[6:0];
              sda_low   <= ~i_TX_Data[7];
              bit_cnt   <= 3'd0;
              ack_phase <= 1'b0;
              state     <= TX_DATA;
            end
          end
          WAIT_STOP: begin
            sda_low <= 1'b0;
          end
          default: begin
            sda_low <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bus-level I2C master drives directed transfers,
// expected pulses and bus bits are queued, and monitor processes pop and compare them.
module tb_i2c_target;

  typedef struct {
    bit    check;
    logic  expv;
    string name;
  } bit_exp_t;

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       master_sda_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_done;
  logic       addr_match;
  logic       busy;
  wire        sda_bus;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] rxQueue[$];
  int         addrQueue[$];
  int         txQueue[$];
  bit_exp_t   bitQueue[$];

  assign sda_bus = master_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_target #(.TARGET_ADDR(7'h42)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_SCL        (scl),
    .ino_SDA      (sda_bus),
    .i_TX_Data    (tx_data),
    .o_RX_Data    (rx_data),
    .o_RX_Valid   (rx_valid),
    .o_TX_Done    (tx_done),
    .o_Addr_Match (addr_match),
    .o_Busy       (busy)
  );

  // 100 MHz system clock; stimulus moves on falling edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Pulse monitor: every valid/done/match pulse must consume a queued expectation.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      assertCount++;
      if (rxQueue.size() == 0) begin
        failCount++;
        $display("[TB] FAIL rx_valid_unexpected: actual data=%h required=no pulse", rx_data);
      end else begin
        logic [7:0] expByte;
        expByte = rxQueue.pop_front();
        if (rx_data !== expByte) begin
          failCount++;
          $display("[TB] FAIL rx_data: actual=%h required=%h", rx_data, expByte);
        end
      end
    end
    if (addr_match === 1'b1) begin
      assertCount++;
      if (addrQueue.size() == 0) begin
        failCount++;
        $display("[TB] FAIL addr_match_unexpected: actual=1 required=0");
      end else begin
        void'(addrQueue.pop_front());
      end
    end
    if (tx_done === 1'b1) begin
      assertCount++;
      if (txQueue.size() == 0) begin
        failCount++;
        $display("[TB] FAIL tx_done_unexpected: actual=1 required=0");
      end else begin
        void'(txQueue.pop_front());
      end
    end
  end

  // Bus monitor: samples SDA in the middle of each queued SCL high phase.
  always @(posedge scl) begin
    if (bitQueue.size() > 0) begin
      bit_exp_t e;
      e = bitQueue.pop_front();
      #40;
      if (e.check) begin
        assertCount++;
        if (sda_bus !== e.expv) begin
          failCount++;
          $display("[TB] FAIL %s: actual sda=%b required sda=%b", e.name, sda_bus, e.expv);
        end
      end
    end
  end

  task automatic sclClock(input logic driveBit, input bit check, input logic expv, input string name);
    bit_exp_t e;
    master_sda_low = ~driveBit;
    #40;
    e.check = check;
    e.expv  = expv;
    e.name  = name;
    bitQueue.push_back(e);
    scl = 1'b1;
    #80;
    scl = 1'b0;
    #40;
  endtask

  task automatic startCond();
    if (scl == 1'b0) begin
      master_sda_low = 1'b0;
      #40;
      scl = 1'b1;
      #40;
    end
    master_sda_low = 1'b1;
    #40;
    scl = 1'b0;
    #40;
  endtask

  task automatic stopCond();
    master_sda_low = 1'b1;
    #40;
    scl = 1'b1;
    #40;
    master_sda_low = 1'b0;
    #80;
  endtask

  // One byte plus its ACK clock. Master-driven bytes check the bus follows the master;
  // target-driven bytes check the bus carries expByte. The ACK slot checks expAck.
  task automatic applyStimulus(input logic [7:0] masterByte, input bit masterDrives,
                               input logic [7:0] expByte, input logic ackDrive,
                               input logic expAck, input string name);
    for (int i = 7; i >= 0; i--) begin
      if (masterDrives)
        sclClock(masterByte[i], 1'b1, masterByte[i], $sformatf("%s_bit%0d", name, i));
      else
        sclClock(1'b1, 1'b1, expByte[i], $sformatf("%s_bit%0d", name, i));
    end
    sclClock(ackDrive, 1'b1, expAck, $sformatf("%s_ack", name));
  endtask

  initial begin
    rst_n          = 1'b0;
    scl            = 1'b1;
    master_sda_low = 1'b0;
    tx_data        = 8'h00;

    // Reset with an idle bus.
    repeat (3) @(negedge clk);
    checkOutput("reset_sda", {7'd0, sda_bus}, 8'h01);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
    checkOutput("reset_tx_done", {7'd0, tx_done}, 8'h00);
    checkOutput("reset_addr_match", {7'd0, addr_match}, 8'h00);
    checkOutput("reset_busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write two bytes to our address.
    $display("[TB] write transfer");
    addrQueue.push_back(1);
    startCond();
    applyStimulus(8'h84, 1'b1, 8'h00, 1'b1, 1'b0, "wr_addr");
    checkOutput("wr_busy_after_addr", {7'd0, busy}, 8'h01);
    rxQueue.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, "wr_byte0");
    rxQueue.push_back(8'h3C);
    applyStimulus(8'h3C, 1'b1, 8'h00, 1'b1, 1'b0, "wr_byte1");
    stopCond();
    checkOutput("wr_busy_after_stop", {7'd0, busy}, 8'h00);
    checkOutput("wr_rx_data_held", rx_data, 8'h3C);

    // Another target's address: bus must only ever show the master.
    $display("[TB] address mismatch");
    startCond();
    applyStimulus(8'h86, 1'b1, 8'h00, 1'b1, 1'b1, "mm_addr");
    checkOutput("mm_busy", {7'd0, busy}, 8'h00);
    applyStimulus(8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, "mm_byte");
    stopCond();

    // Read two bytes; ACK the first, NACK the second.
    $display("[TB] read transfer");
    tx_data = 8'h5A;
    addrQueue.push_back(1);
    startCond();
    applyStimulus(8'h85, 1'b1, 8'h00, 1'b1, 1'b0, "rd_addr");
    tx_data = 8'hC3;
    txQueue.push_back(1);
    applyStimulus(8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, "rd_byte0");
    applyStimulus(8'h00, 1'b0, 8'hC3, 1'b1, 1'b1, "rd_byte1");
    sclClock(1'b1, 1'b1, 1'b1, "rd_after_nack");
    checkOutput("rd_busy_until_stop", {7'd0, busy}, 8'h01);
    stopCond();
    checkOutput("rd_busy_after_stop", {7'd0, busy}, 8'h00);

    // Write one byte, repeated START, read one byte.
    $display("[TB] repeated start");
    addrQueue.push_back(1);
    startCond();
    applyStimulus(8'h84, 1'b1, 8'h00, 1'b1, 1'b0, "rs_wr_addr");
    rxQueue.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 8'h00, 1'b1, 1'b0, "rs_wr_byte");
    tx_data = 8'h96;
    addrQueue.push_back(1);
    startCond();
    applyStimulus(8'h85, 1'b1, 8'h00, 1'b1, 1'b0, "rs_rd_addr");
    applyStimulus(8'h00, 1'b0, 8'h96, 1'b1, 1'b1, "rs_rd_byte");
    stopCond();
    checkOutput("rs_busy_after_stop", {7'd0, busy}, 8'h00);

    // Reset while the target is pulling the address ACK low.
    $display("[TB] reset mid-transfer");
    addrQueue.push_back(1);
    startCond();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] addrByte;
      addrByte = 8'h84;
      sclClock(addrByte[i], 1'b1, addrByte[i], $sformatf("mr_addr_bit%0d", i));
    end
    master_sda_low = 1'b0;
    #40;
    scl = 1'b1;
    #40;
    checkOutput("mr_ack_driven", {7'd0, sda_bus}, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mr_sda_released", {7'd0, sda_bus}, 8'h01);
    checkOutput("mr_busy", {7'd0, busy}, 8'h00);
    scl = 1'b0;
    #40;
    stopCond();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("mr_busy_after", {7'd0, busy}, 8'h00);

    // Every queued expectation must have been consumed.
    repeat (10) @(negedge clk);
    checkOutput("rx_pulses_missing", rxQueue.size()[7:0], 8'h00);
    checkOutput("addr_pulses_missing", addrQueue.size()[7:0], 8'h00);
    checkOutput("tx_pulses_missing", txQueue.size()[7:0], 8'h00);
    checkOutput("bus_checks_missing", bitQueue.size()[7:0], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
